cache_ctrl_2way: RTL and testbench
==================================

Name: cache_ctrl_2way

Overview:
Control FSM for the 2-way set-associative cache. It sits between the CPU-side memory-stage request and the two cache way arrays plus the four-bank main memory. It resolves hit/miss, picks a victim way, and sequences writeback and fill. It drives the write-enable and next-state of the single-bit victim-way register (the 1-bit enabled register instantiated beside it) and consumes that register's output.

Parameters:
MEM_LAT, 2, cycles from a memory read issue to valid data on mem_data_out
WORDS, 4, words per cache line (offset field = 3 bits, word-aligned)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
Rd  in  1  CPU read request (level, held until done)
Wr  in  1  CPU write request (level, held until done)
Addr  in  16  CPU address: tag[15:11], index[10:3], offset[2:0]
hit0/hit1  in  1  way compare hit (tag match and valid)
valid0/valid1  in  1  way valid at index
dirty0/dirty1  in  1  way dirty at index
tag0/tag1  in  5  stored tag at index, for writeback address
mem_stall  in  1  memory bank busy; an issued access is not accepted
victim_q  in  1  current victim-way register value
victim_we  out  1  victim register write enable
victim_d  out  1  victim register next value
way_en  out  2  per-way cache enable
cache_comp  out  1  cache compare mode (1 = CPU access, 0 = fill/readout)
cache_write  out  1  cache write strobe
cache_offset  out  3  word offset driven to the ways
mem_addr  out  16  main-memory address
mem_rd/mem_wr  out  1  main-memory read/write strobe
fill_sel  out  1  cache data-in select: 0 = CPU data, 1 = memory data
Done  out  1  one-cycle pulse: request complete
Stall  out  1  CPU must hold the request
CacheHit  out  1  with Done: request hit in COMPARE

Behaviour:
- Reset value of all outputs is 0 and the state is IDLE. Reset is asynchronous and takes effect mid-operation: any writeback or fill is abandoned and nothing is retried.
- IDLE: if Rd or Wr is high (Wr has priority if both are high), go to COMPARE. Stall=0.
- COMPARE: way_en=2'b11, cache_comp=1, cache_write=Wr, cache_offset=Addr[2:0]. victim_we=1 and victim_d=~victim_q; the toggle happens once per request, in this cycle only.
- Hit in either way: Done=1, CacheHit=1, back to IDLE. This is a 1-cycle hit latency after acceptance. If hit0 and hit1 are both high, that is illegal; way 0 wins.
- Miss: choose the victim in this order, using the pre-toggle victim_q: way 0 if !valid0; else way 1 if !valid1; else way victim_q. Latch the choice into the internal vsel register.
- Miss, then go to WB if the chosen way is valid and dirty; otherwise go to FILL.
- WB (k = 0..3): cache_comp=0, way_en=onehot(vsel), cache_offset=2k, mem_wr=1, mem_addr={tag_vsel, index, 2k}. Advance k only if !mem_stall. After k=3 is accepted, go to FILL.
- FILL: issue mem_rd for words k = 0..3 at {Addr tag, index, 2k}, advancing on !mem_stall.
- FILL data: word k is written MEM_LAT cycles after its accepted issue, with cache_write=1, fill_sel=1, way_en=onehot(vsel), cache_comp=0, cache_offset=2k.
- Leaving FILL: after the last fill write, go to RETRY.
- RETRY: identical to COMPARE, but victim_we=0. The access must hit; assert Done=1, CacheHit=0, then go to IDLE.
- Stall=1 in every state except IDLE and the Done cycle.
- Issue and fill counters are 2-bit and wrap at WORDS; the fill counter is tracked with a MEM_LAT-deep valid shift register of issued read indices.

Decomposition:
- Shared package: state encoding localparams (IDLE, COMPARE, WB, FILL, RETRY), address field widths/positions, WORDS.
- One natural sub-module, fill_tracker: the MEM_LAT-deep shift register pairing each accepted read issue with its return cycle and offset.

Test Plan:
1. Reset, then Rd to Addr 0x0010 with hit0=1 -> Done and CacheHit high exactly 1 cycle after acceptance; victim_we=1, victim_d=~victim_q; no mem_rd.
2. Rd miss with valid0=0, valid1=1 -> vsel=0, no WB; mem_rd at 0x0010, 0x0012, 0x0014, 0x0016 on consecutive cycles; fill writes at offsets 0,2,4,6 MEM_LAT cycles later; Done with CacheHit=0.
3. Wr miss with both ways valid, victim_q=1, dirty1=1, tag1=5'h1F -> 4 mem_wr at 0xF810..0xF816 from way 1, then fill into way 1, then a RETRY write with cache_write=1.
4. mem_stall high 3 cycles during WB k=2 -> mem_addr and mem_wr held, k does not advance, and the total miss latency grows by exactly 3.
5. rst asserted mid-FILL -> all outputs 0 asynchronously, state IDLE, Done never pulses; the next request is handled normally.
6. Four back-to-back hit requests -> victim_d alternates 1,0,1,0 from victim_q=0 at reset; exactly one victim_we per request.

Source files
------------

// File: rtl/cache_ctrl_2way_pkg.sv
// Shared types, address-field geometry and helpers for the 2-way cache controller.
package cache_ctrl_2way_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned TAG_W       = 5;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned OFF_W       = 3;
    localparam int unsigned TAG_LSB     = 11;
    localparam int unsigned IDX_LSB     = 3;
    localparam int unsigned WORDS       = 4;
    localparam int unsigned WCNT_W      = 2;
    localparam int unsigned MEM_LAT_DEF = 2;

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_WB      = 3'd2,
        S_FILL    = 3'd3,
        S_RETRY   = 3'd4
    } state_t;

    function automatic logic [1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

    // Words are 16-bit, so word k sits at byte offset 2k.
    function automatic logic [OFF_W-1:0] word_offset(input logic [WCNT_W-1:0] k);
        return {k, 1'b0};
    endfunction

endpackage

// File: rtl/cache_ctrl_2way_fill_tracker.sv
// Delay line pairing each accepted memory read issue with the cycle its data returns.
module cache_ctrl_2way_fill_tracker
    import cache_ctrl_2way_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WCNT_W-1:0] push_idx,
    output logic              ret_vld,
    output logic [WCNT_W-1:0] ret_idx
);

    logic [MEM_LAT-1:0]             vld_q, vld_d;
    logic [MEM_LAT-1:0][WCNT_W-1:0] idx_q, idx_d;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = push;
        idx_d[0] = push_idx;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign ret_vld = vld_q[MEM_LAT-1];
    assign ret_idx = idx_q[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_2way.sv
// Control FSM for the 2-way set-associative cache: hit/miss resolution,
// victim selection, dirty-line writeback and line fill from main memory.
module cache_ctrl_2way
    import cache_ctrl_2way_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              hit0,
    input  logic              hit1,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              dirty0,
    input  logic              dirty1,
    input  logic [TAG_W-1:0]  tag0,
    input  logic [TAG_W-1:0]  tag1,
    input  logic              mem_stall,
    input  logic              victim_q,
    output logic              victim_we,
    output logic              victim_d,
    output logic [1:0]        way_en,
    output logic              cache_comp,
    output logic              cache_write,
    output logic [OFF_W-1:0]  cache_offset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              fill_sel,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit
);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] k_q, k_d;
    logic              issue_done_q, issue_done_d;
    logic              vsel_q, vsel_d;

    logic              fill_push;
    logic              fill_vld;
    logic [WCNT_W-1:0] fill_idx;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  wb_tag;
    logic              miss_vsel;
    logic              miss_wb;

    assign req_tag = Addr[TAG_LSB +: TAG_W];
    assign req_idx = Addr[IDX_LSB +: IDX_W];
    assign wb_tag  = vsel_q ? tag1 : tag0;

    // Prefer an empty way; only fall back to the round-robin victim when both are valid.
    assign miss_vsel = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : victim_q);
    assign miss_wb   = miss_vsel ? (valid1 && dirty1) : (valid0 && dirty0);

    cache_ctrl_2way_fill_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_fill_tracker (
        .clk      (clk),
        .rst      (rst),
        .push     (fill_push),
        .push_idx (k_q),
        .ret_vld  (fill_vld),
        .ret_idx  (fill_idx)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        issue_done_d = issue_done_q;
        vsel_d       = vsel_q;
        fill_push    = 1'b0;
        victim_we    = 1'b0;
        victim_d     = 1'b0;
        way_en       = 2'b00;
        cache_comp   = 1'b0;
        cache_write  = 1'b0;
        cache_offset = '0;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        fill_sel     = 1'b0;
        Done         = 1'b0;
        Stall        = 1'b1;
        CacheHit     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                Stall = 1'b0;
                if (Rd || Wr) begin
                    state_d = S_COMPARE;
                end
            end

            S_COMPARE: begin
                way_en       = 2'b11;
                cache_comp   = 1'b1;
                cache_write  = Wr;
                cache_offset = Addr[OFF_W-1:0];
                victim_we    = 1'b1;
                victim_d     = ~victim_q;
                if (hit0 || hit1) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    Stall    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    vsel_d       = miss_vsel;
                    k_d          = '0;
                    issue_done_d = 1'b0;
                    state_d      = miss_wb ? S_WB : S_FILL;
                end
            end

            S_WB: begin
                way_en       = way_onehot(vsel_q);
                cache_offset = word_offset(k_q);
                mem_wr       = 1'b1;
                mem_addr     = {wb_tag, req_idx, word_offset(k_q)};
                if (!mem_stall) begin
                    k_d = k_q + 2'd1;
                    if (k_q == LAST_WORD) begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (!issue_done_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = {req_tag, req_idx, word_offset(k_q)};
                    if (!mem_stall) begin
                        fill_push = 1'b1;
                        k_d       = k_q + 2'd1;
                        if (k_q == LAST_WORD) begin
                            issue_done_d = 1'b1;
                        end
                    end
                end
                // Returning words land MEM_LAT cycles after their accepted issue.
                if (fill_vld) begin
                    cache_write  = 1'b1;
                    fill_sel     = 1'b1;
                    way_en       = way_onehot(vsel_q);
                    cache_offset = word_offset(fill_idx);
                    if (fill_idx == LAST_WORD) begin
                        state_d = S_RETRY;
                    end
                end
            end

            S_RETRY: begin
                way_en       = 2'b11;
                cache_comp   = 1'b1;
                cache_write  = Wr;
                cache_offset = Addr[OFF_W-1:0];
                Done         = 1'b1;
                Stall        = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            issue_done_q <= 1'b0;
            vsel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            issue_done_q <= issue_done_d;
            vsel_q       <= vsel_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed self-checking bench for cache_ctrl_2way with an external victim-way register.
module tb_cache_ctrl_2way;
    import cache_ctrl_2way_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        Rd, Wr;
    logic [15:0] Addr;
    logic        hit0, hit1, valid0, valid1, dirty0, dirty1;
    logic [4:0]  tag0, tag1;
    logic        mem_stall;
    logic        victim_q;
    logic        victim_we, victim_d;
    logic [1:0]  way_en;
    logic        cache_comp, cache_write;
    logic [2:0]  cache_offset;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr, fill_sel;
    logic        Done, Stall, CacheHit;
    logic [30:0] outs;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-request capture
    logic [15:0] wr_addr[$];
    logic [1:0]  wr_way[$];
    logic [15:0] rd_addr[$];
    int          rd_cyc[$];
    logic [2:0]  fw_off[$];
    int          fw_cyc[$];
    logic [1:0]  fw_way[$];
    int          done_cyc;
    logic        done_hit, done_write, done_comp;
    logic [2:0]  done_off;
    logic [1:0]  done_way;
    int          vwe_cnt;
    logic        vd_first;
    int          stall_bad;

    cache_ctrl_2way dut (
        .clk          (clk),
        .rst          (rst),
        .Rd           (Rd),
        .Wr           (Wr),
        .Addr         (Addr),
        .hit0         (hit0),
        .hit1         (hit1),
        .valid0       (valid0),
        .valid1       (valid1),
        .dirty0       (dirty0),
        .dirty1       (dirty1),
        .tag0         (tag0),
        .tag1         (tag1),
        .mem_stall    (mem_stall),
        .victim_q     (victim_q),
        .victim_we    (victim_we),
        .victim_d     (victim_d),
        .way_en       (way_en),
        .cache_comp   (cache_comp),
        .cache_write  (cache_write),
        .cache_offset (cache_offset),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .fill_sel     (fill_sel),
        .Done         (Done),
        .Stall        (Stall),
        .CacheHit     (CacheHit)
    );

    always #5 clk = ~clk;

    // The 1-bit victim-way register that lives beside the controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            victim_q <= 1'b0;
        else if (victim_we) victim_q <= victim_d;
    end

    assign outs = {victim_we, victim_d, way_en, cache_comp, cache_write, cache_offset,
                   mem_addr, mem_rd, mem_wr, fill_sel, Done, Stall, CacheHit};

    task automatic do_reset();
        rst = 1'b1;
        Rd = 1'b0; Wr = 1'b0; mem_stall = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one request from IDLE (cycle 0) and records what the controller does each cycle.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input int stall_from, input int stall_len, input logic [1:0] retry_hits);
        logic last_fill;
        wr_addr.delete(); wr_way.delete(); rd_addr.delete(); rd_cyc.delete();
        fw_off.delete(); fw_cyc.delete(); fw_way.delete();
        done_cyc = -1; done_hit = 1'bx; done_write = 1'bx; done_comp = 1'bx;
        done_off = 'x; done_way = 'x; vwe_cnt = 0; vd_first = 1'bx; stall_bad = 0;
        last_fill = 1'b0;
        Rd = rd; Wr = wr; Addr = addr;
        for (int c = 0; c < 60; c++) begin
            mem_stall = (c >= stall_from) && (c < stall_from + stall_len);
            if (last_fill) {hit1, hit0} = retry_hits;
            @(negedge clk);
            if (mem_wr) begin wr_addr.push_back(mem_addr); wr_way.push_back(way_en); end
            if (mem_rd) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(c); end
            if (cache_write && fill_sel) begin
                fw_off.push_back(cache_offset); fw_cyc.push_back(c); fw_way.push_back(way_en);
                if (cache_offset == 3'd6) last_fill = 1'b1;
            end
            if (victim_we) begin
                if (vwe_cnt == 0) vd_first = victim_d;
                vwe_cnt++;
            end
            if (Stall !== ((c > 0) && !Done)) stall_bad++;
            if (Done) begin
                done_cyc = c; done_hit = CacheHit; done_write = cache_write;
                done_comp = cache_comp; done_off = cache_offset; done_way = way_en;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0; mem_stall = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Rd = 1'b0; Wr = 1'b0; Addr = '0; hit0 = 0; hit1 = 0; valid0 = 0; valid1 = 0;
        dirty0 = 0; dirty1 = 0; tag0 = '0; tag1 = '0; mem_stall = 0;
        #1;
        tests_run++;
        if (outs !== 31'd0) begin tests_failed++; $display("FAIL reset_outs: got %h expected 0", outs); end
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outs !== 31'd0) begin tests_failed++; $display("FAIL idle_outs: got %h expected 0", outs); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hit();
        valid0 = 1; valid1 = 1; hit0 = 1; hit1 = 0;
        run_req(1'b1, 1'b0, 16'h0010, 0, 0, 2'b00);
        tests_run++;
        if (done_cyc !== 1 || done_hit !== 1'b1) begin tests_failed++;
            $display("FAIL hit_latency: got cyc=%0d hit=%b expected cyc=1 hit=1", done_cyc, done_hit); end
        tests_run++;
        if (vwe_cnt !== 1 || vd_first !== 1'b1) begin tests_failed++;
            $display("FAIL hit_victim: got we=%0d d=%b expected we=1 d=1", vwe_cnt, vd_first); end
        tests_run++;
        if (rd_addr.size() !== 0 || wr_addr.size() !== 0) begin tests_failed++;
            $display("FAIL hit_nomem: got rd=%0d wr=%0d expected 0 0", rd_addr.size(), wr_addr.size()); end
        tests_run++;
        if (done_way !== 2'b11 || done_comp !== 1'b1 || done_write !== 1'b0 || stall_bad !== 0) begin
            tests_failed++;
            $display("FAIL hit_ctrl: got way=%b comp=%b wr=%b stallbad=%0d expected 11 1 0 0",
                     done_way, done_comp, done_write, stall_bad); end
    endtask

    task automatic test_wb_fill();
        valid0 = 1; valid1 = 1; dirty0 = 0; dirty1 = 1; tag0 = 5'h03; tag1 = 5'h1F;
        hit0 = 0; hit1 = 0;
        run_req(1'b0, 1'b1, 16'h0012, 0, 0, 2'b10);
        tests_run++;
        if (vd_first !== 1'b0 || vwe_cnt !== 1) begin tests_failed++;
            $display("FAIL wb_victim: got d=%b we=%0d expected 0 1", vd_first, vwe_cnt); end
        tests_run++;
        if (wr_addr.size() !== 4) begin tests_failed++;
            $display("FAIL wb_count: got %0d expected 4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== 16'hF810 + 16'(2 * i) || wr_way[i] !== 2'b10) begin tests_failed++;
                $display("FAIL wb_word%0d: got addr=%h way=%b expected %h 10", i, wr_addr[i], wr_way[i],
                         16'hF810 + 16'(2 * i)); end
        end
        tests_run++;
        if (rd_addr.size() !== 4) begin tests_failed++;
            $display("FAIL wbfill_rdcount: got %0d expected 4", rd_addr.size()); end
        for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
            tests_run++;
            if (rd_addr[i] !== 16'h0010 + 16'(2 * i) || rd_cyc[i] !== 6 + i) begin tests_failed++;
                $display("FAIL wbfill_rd%0d: got addr=%h cyc=%0d expected %h %0d", i, rd_addr[i], rd_cyc[i],
                         16'h0010 + 16'(2 * i), 6 + i); end
        end
        tests_run++;
        if (fw_off.size() !== 4) begin tests_failed++;
            $display("FAIL wbfill_fwcount: got %0d expected 4", fw_off.size()); end
        for (int i = 0; i < 4 && i < fw_off.size(); i++) begin
            tests_run++;
            if (fw_off[i] !== 3'(2 * i) || fw_cyc[i] !== 8 + i || fw_way[i] !== 2'b10) begin tests_failed++;
                $display("FAIL wbfill_fw%0d: got off=%0d cyc=%0d way=%b expected %0d %0d 10", i, fw_off[i],
                         fw_cyc[i], fw_way[i], 2 * i, 8 + i); end
        end
        tests_run++;
        if (done_cyc !== 12 || done_hit !== 1'b0 || done_write !== 1'b1 || done_off !== 3'd2) begin
            tests_failed++;
            $display("FAIL wb_retry: got cyc=%0d hit=%b wr=%b off=%0d expected 12 0 1 2",
                     done_cyc, done_hit, done_write, done_off); end
        tests_run++;
        if (stall_bad !== 0) begin tests_failed++;
            $display("FAIL wb_stall_out: got %0d bad cycles expected 0", stall_bad); end
    endtask

    task automatic test_mem_stall();
        logic [15:0] exp_wr[7];
        exp_wr = '{16'h5020, 16'h5022, 16'h5024, 16'h5024, 16'h5024, 16'h5024, 16'h5026};
        valid0 = 1; valid1 = 1; dirty0 = 1; dirty1 = 0; tag0 = 5'h0A; tag1 = 5'h02;
        hit0 = 0; hit1 = 0;
        run_req(1'b1, 1'b0, 16'h0020, 4, 3, 2'b01);
        tests_run++;
        if (wr_addr.size() !== 7) begin tests_failed++;
            $display("FAIL stall_wrcycles: got %0d expected 7", wr_addr.size()); end
        for (int i = 0; i < 7 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== exp_wr[i] || wr_way[i] !== 2'b01) begin tests_failed++;
                $display("FAIL stall_wb%0d: got addr=%h way=%b expected %h 01", i, wr_addr[i], wr_way[i],
                         exp_wr[i]); end
        end
        tests_run++;
        if (rd_addr.size() !== 4 || fw_cyc.size() !== 4) begin tests_failed++;
            $display("FAIL stall_fill: got rd=%0d fw=%0d expected 4 4", rd_addr.size(), fw_cyc.size()); end
        else begin
            tests_run++;
            if (rd_addr[0] !== 16'h0020 || rd_cyc[0] !== 9 || fw_cyc[0] !== 11 || fw_way[0] !== 2'b01) begin
                tests_failed++;
                $display("FAIL stall_fill0: got addr=%h rc=%0d fc=%0d way=%b expected 0020 9 11 01",
                         rd_addr[0], rd_cyc[0], fw_cyc[0], fw_way[0]); end
        end
        tests_run++;
        if (done_cyc !== 15 || done_hit !== 1'b0 || vd_first !== 1'b1) begin tests_failed++;
            $display("FAIL stall_latency: got cyc=%0d hit=%b vd=%b expected 15 0 1", done_cyc, done_hit, vd_first); end
    endtask

    task automatic test_fill_clean();
        valid0 = 0; valid1 = 1; dirty0 = 1; dirty1 = 1; tag0 = 5'h07; tag1 = 5'h09;
        hit0 = 0; hit1 = 0;
        run_req(1'b1, 1'b0, 16'h0010, 0, 0, 2'b01);
        tests_run++;
        if (wr_addr.size() !== 0) begin tests_failed++;
            $display("FAIL clean_nowb: got %0d expected 0", wr_addr.size()); end
        tests_run++;
        if (rd_addr.size() !== 4 || fw_off.size() !== 4) begin tests_failed++;
            $display("FAIL clean_counts: got rd=%0d fw=%0d expected 4 4", rd_addr.size(), fw_off.size()); end
        for (int i = 0; i < 4 && i < rd_addr.size() && i < fw_off.size(); i++) begin
            tests_run++;
            if (rd_addr[i] !== 16'h0010 + 16'(2 * i) || rd_cyc[i] !== 2 + i ||
                fw_off[i] !== 3'(2 * i) || fw_cyc[i] !== 4 + i || fw_way[i] !== 2'b01) begin
                tests_failed++;
                $display("FAIL clean_word%0d: got rd=%h@%0d fw=%0d@%0d way=%b expected %h@%0d %0d@%0d 01",
                         i, rd_addr[i], rd_cyc[i], fw_off[i], fw_cyc[i], fw_way[i],
                         16'h0010 + 16'(2 * i), 2 + i, 2 * i, 4 + i); end
        end
        tests_run++;
        if (done_cyc !== 8 || done_hit !== 1'b0 || done_write !== 1'b0 || vd_first !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_done: got cyc=%0d hit=%b wr=%b vd=%b expected 8 0 0 0",
                     done_cyc, done_hit, done_write, vd_first); end
    endtask

    task automatic test_reset_mid_fill();
        int done_seen;
        int rd_seen;
        valid0 = 0; valid1 = 1; dirty0 = 0; dirty1 = 0; hit0 = 0; hit1 = 0;
        Rd = 1'b1; Addr = 16'h0030;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0032) begin tests_failed++;
            $display("FAIL midfill_pre: got rd=%b addr=%h expected 1 0032", mem_rd, mem_addr); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (outs !== 31'd0 || dut.state_q !== S_IDLE) begin tests_failed++;
            $display("FAIL midfill_async: got outs=%h state=%0d expected 0 0", outs, dut.state_q); end
        Rd = 1'b0;
        done_seen = 0; rd_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (Done) done_seen++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (Done) done_seen++;
            if (mem_rd) rd_seen++;
        end
        tests_run++;
        if (done_seen !== 0 || rd_seen !== 0) begin tests_failed++;
            $display("FAIL midfill_quiet: got done=%0d rd=%0d expected 0 0", done_seen, rd_seen); end
        @(posedge clk);
        #1;
        valid0 = 1; hit1 = 1;
        run_req(1'b1, 1'b0, 16'h0010, 0, 0, 2'b00);
        tests_run++;
        if (done_cyc !== 1 || done_hit !== 1'b1 || vd_first !== 1'b1) begin tests_failed++;
            $display("FAIL midfill_next: got cyc=%0d hit=%b vd=%b expected 1 1 1", done_cyc, done_hit, vd_first); end
    endtask

    task automatic test_back_to_back();
        logic exp_vd;
        do_reset();
        valid0 = 1; valid1 = 1;
        exp_vd = 1'b1;
        for (int r = 0; r < 4; r++) begin
            hit0 = 1;
            run_req(1'b1, 1'b0, 16'h0040 + 16'(2 * r), 0, 0, 2'b00);
            tests_run++;
            if (vd_first !== exp_vd || vwe_cnt !== 1 || done_cyc !== 1) begin tests_failed++;
                $display("FAIL b2b_req%0d: got vd=%b we=%0d cyc=%0d expected %b 1 1",
                         r, vd_first, vwe_cnt, done_cyc, exp_vd); end
            exp_vd = ~exp_vd;
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_wb_fill();
        test_mem_stall();
        test_fill_clean();
        test_reset_mid_fill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
